// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared PS/2 state encoding, default timing constants and parity helper
package ps2_host_tx_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_INHIBIT, ST_START, ST_SEND, ST_ACK, ST_WAIT_IDLE, ST_ERROR
  } ps2_state_e;
  localparam int PS2_INHIBIT_CYCLES    = 2500;
  localparam int PS2_START_HOLD_CYCLES = 25;
  localparam int PS2_TIMEOUT_CYCLES    = 50000;
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: byte-send handshake between a command source and the PS/2 host transmitter
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  modport master (output tx_data, tx_valid, input tx_ready, tx_done, tx_error);
  modport slave  (input tx_data, tx_valid, output tx_ready, tx_done, tx_error);
endinterface

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchronizer for an asynchronous PS/2 line plus falling-edge pulse
module ps2_sync_edge (
  input  logic clock,
  input  logic resetn,
  input  logic line_i,
  output logic sync_o,
  output logic fall_o
);
  logic meta_q, sync_q, prev_q;
  always_ff @(posedge clock)
    if (!resetn) {meta_q, sync_q, prev_q} <= '1;
    else {meta_q, sync_q, prev_q} <= {line_i, meta_q, sync_q};
  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter (inhibit, start, 8 data + odd parity + stop, ACK)
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES    = PS2_INHIBIT_CYCLES,
  parameter int START_HOLD_CYCLES = PS2_START_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES    = PS2_TIMEOUT_CYCLES
) (
  input  logic         clock,
  input  logic         resetn,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe
);
  localparam int PW = INHIBIT_CYCLES > START_HOLD_CYCLES ? INHIBIT_CYCLES : START_HOLD_CYCLES;
  localparam int CW = $clog2(PW + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  ps2_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    edge_q, edge_d;
  logic [8:0]    shift_q, shift_d;
  logic clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
  logic done_q, done_d, error_q, error_d, ready_q, ready_d;
  logic clk_sync, dat_sync, clk_fall, unused_dat_fall, tmo_hit, inh_last, hold_last;

  ps2_sync_edge u_clk (.clock, .resetn, .line_i(ps2_clk_in), .sync_o(clk_sync), .fall_o(clk_fall));
  ps2_sync_edge u_dat (.clock, .resetn, .line_i(ps2_dat_in), .sync_o(dat_sync), .fall_o(unused_dat_fall));

  assign tmo_hit   = tmo_q == TW'(TIMEOUT_CYCLES - 1);
  assign inh_last  = cnt_q == CW'(INHIBIT_CYCLES - 1);
  assign hold_last = cnt_q == CW'(START_HOLD_CYCLES - 1);

  always_ff @(posedge clock)
    if (!resetn) begin
      state_q <= ST_IDLE;
      {cnt_q, tmo_q, edge_q, shift_q} <= '0;
      {clk_oe_q, dat_oe_q, done_q, error_q} <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      {cnt_q, tmo_q, edge_q, shift_q} <= {cnt_d, tmo_d, edge_d, shift_d};
      {clk_oe_q, dat_oe_q, done_q, error_q, ready_q} <= {clk_oe_d, dat_oe_d, done_d, error_d, ready_d};
    end

  // Bits leave from shift_q[0]; ones shift in so the tenth edge naturally releases data (stop bit).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    edge_d  = edge_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: if (tx.tx_valid && ready_q) begin
        state_d = ST_INHIBIT;
        cnt_d   = '0;
        shift_d = {odd_parity(tx.tx_data), tx.tx_data};
      end
      ST_INHIBIT: begin
        cnt_d   = inh_last ? '0 : cnt_q + 1'b1;
        state_d = inh_last ? ST_START : ST_INHIBIT;
      end
      ST_START: begin
        cnt_d   = hold_last ? '0 : cnt_q + 1'b1;
        state_d = hold_last ? ST_SEND : ST_START;
        tmo_d   = '0;
        edge_d  = '0;
      end
      ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_hit) state_d = ST_ERROR;
        else if (state_q == ST_SEND && clk_fall) begin
          edge_d  = edge_q + 1'b1;
          shift_d = {1'b1, shift_q[8:1]};
          state_d = edge_q == 4'd9 ? ST_ACK : ST_SEND;
        end else if (state_q == ST_ACK && clk_fall) begin
          edge_d  = edge_q + 1'b1;
          state_d = dat_sync ? ST_ERROR : ST_WAIT_IDLE;
        end else if (state_q == ST_WAIT_IDLE && clk_sync && dat_sync) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_d  = state_d == ST_IDLE;
    clk_oe_d = state_d == ST_INHIBIT || state_d == ST_START;
    dat_oe_d = state_d == ST_START ? 1'b1 :
               state_d != ST_SEND ? 1'b0 :
               state_q == ST_SEND && clk_fall ? ~shift_q[0] : dat_oe_q;
    done_d   = state_q == ST_WAIT_IDLE && state_d == ST_IDLE;
    error_d  = state_d == ST_ERROR;
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_dat_oe  = dat_oe_q;
  assign tx.tx_ready = ready_q;
  assign tx.tx_done  = done_q;
  assign tx.tx_error = error_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench driving ps2_host_tx against an open-drain PS/2 device model
module tb_ps2_host_tx;
  localparam int INH = 100, HOLD = 10, TMO = 2000, HALF = 40;
  typedef struct {
    bit         err;
    bit         chk_pat;
    logic [9:0] pat;
  } exp_t;

  logic clock = 0, resetn = 0;
  logic dev_clk = 1, dev_dat = 1;
  logic ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  int   cyc = 0, tests = 0, fails = 0;
  int   t_clk_lo = 0, t_dat_lo = 0, t_rel = 0, t_err = 0;
  logic pco = 0, pdo = 0;
  logic [9:0] cap_pat = '0;
  exp_t q[$];
  exp_t mon_e;

  ps2_host_tx_if tx();
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .resetn(resetn), .tx(tx),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
  );

  // Open-drain wired-AND of host and device drivers.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (ps2_clk_oe && !pco) t_clk_lo = cyc;
    if (ps2_dat_oe && !pdo && ps2_clk_oe) t_dat_lo = cyc;
    if (!ps2_clk_oe && pco) t_rel = cyc;
    if (tx.tx_error) t_err = cyc;
    pco = ps2_clk_oe;
    pdo = ps2_dat_oe;
  end

  always @(negedge clock)
    if (tx.tx_done || tx.tx_error) begin
      if (q.size() == 0) check("unexpected_pulse", {30'd0, tx.tx_done, tx.tx_error}, 32'd0);
      else begin
        mon_e = q.pop_front();
        check("pulse_kind", {30'd0, tx.tx_done, tx.tx_error}, mon_e.err ? 32'd1 : 32'd2);
        if (mon_e.chk_pat) check("bit_pattern", {22'd0, cap_pat}, {22'd0, mon_e.pat});
        check("lines_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      end
    end

  task automatic expect_evt(input bit err, input bit chk, input logic [9:0] pat);
    exp_t e;
    e.err = err; e.chk_pat = chk; e.pat = pat;
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    tx.tx_valid = 1; tx.tx_data = b;
    @(negedge clock);
    tx.tx_valid = 0; tx.tx_data = ~b;
  endtask

  task automatic wait_release();
    int k = 0;
    bit hi = 0;
    while (k < INH + HOLD + 20 && !(hi && !ps2_clk_oe)) begin
      @(negedge clock);
      hi |= ps2_clk_oe;
      k++;
    end
    check("release_seen", {31'd0, hi && !ps2_clk_oe}, 32'd1);
  endtask

  task automatic wait_ready(input int bound);
    int k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!tx.tx_ready && k < bound);
    check("ready_return", {31'd0, tx.tx_ready}, 32'd1);
  endtask

  // Device clocks n_edges falls; samples host data before each rise; ack pulls data low on edge 11.
  task automatic dev_frame(input int n_edges, input bit ack);
    cap_pat = '0;
    repeat (HALF) @(negedge clock);
    for (int n = 1; n <= n_edges; n++) begin
      if (n == 11) dev_dat = !ack;
      dev_clk = 0;
      repeat (HALF) @(negedge clock);
      if (n <= 10) cap_pat[n-1] = ps2_dat_oe;
      dev_clk = 1;
      dev_dat = 1;
      repeat (HALF) @(negedge clock);
    end
  endtask

  initial begin
    tx.tx_valid = 0;
    tx.tx_data  = '0;
    repeat (3) @(negedge clock);
    check("rst_ready", {31'd0, tx.tx_ready}, 32'd1);
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    check("rst_done", {31'd0, tx.tx_done}, 32'd0);
    check("rst_error", {31'd0, tx.tx_error}, 32'd0);
    resetn = 1;
    // 0xED with ACK
    expect_evt(0, 1, 10'h012);
    send(8'hED);
    wait_release();
    dev_frame(11, 1);
    wait_ready(TMO);
    // 0x00: parity released; inhibit and start-hold durations
    expect_evt(0, 1, 10'h0FF);
    send(8'h00);
    wait_release();
    dev_frame(11, 1);
    wait_ready(TMO);
    check("inhibit_len", t_dat_lo - t_clk_lo, INH);
    check("start_hold_len", t_rel - t_dat_lo, HOLD);
    // silent device: timeout
    expect_evt(1, 0, '0);
    send(8'h55);
    wait_release();
    wait_ready(TMO + 100);
    check("timeout_len", t_err - t_rel, TMO);
    // missing ACK
    expect_evt(1, 1, 10'h1FE);
    send(8'h01);
    wait_release();
    dev_frame(11, 0);
    wait_ready(TMO);
    // reset after edge 4 aborts silently, then 0xF4 completes
    send(8'h3C);
    wait_release();
    dev_frame(4, 1);
    @(negedge clock);
    resetn = 0;
    @(negedge clock);
    check("abort_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    check("abort_ready", {31'd0, tx.tx_ready}, 32'd1);
    resetn = 1;
    expect_evt(0, 1, 10'h10B);
    send(8'hF4);
    wait_release();
    dev_frame(11, 1);
    wait_ready(TMO);
    // stray request mid-frame is ignored
    expect_evt(0, 1, 10'h0C3);
    send(8'h3C);
    wait_release();
    fork
      dev_frame(11, 1);
      begin
        repeat (3 * HALF) @(negedge clock);
        check("busy_not_ready", {31'd0, tx.tx_ready}, 32'd0);
        tx.tx_valid = 1;
        tx.tx_data  = 8'hAA;
        @(negedge clock);
        tx.tx_valid = 0;
      end
    join
    wait_ready(TMO);
    expect_evt(0, 1, 10'h012);
    send(8'hED);
    wait_release();
    dev_frame(11, 1);
    wait_ready(TMO);
    repeat (10) @(negedge clock);
    check("scoreboard_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
